ysyx_22041752_wbu: RTL and testbench

YSYX_22041752_WBU -- requirements
Module: ysyx_22041752_wbu

---
 rtl/ysyx_22041752_wbu.sv | 134 +++++++++++++
 tb/tb_ysyx_22041752_wbu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_wbu.sv
// Write-back unit: a 2-entry in-order retirement buffer with register-file write port,
// decode forwarding lookup and a retired-instruction counter.
module ysyx_22041752_wbu #(
  parameter int DATA_WD = 64,
  parameter int ADDR_WD = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms_valid,
  output logic               ws_ready,
  input  logic [ADDR_WD-1:0] ms_rd,
  input  logic               ms_rd_we,
  input  logic [1:0]         ms_res_sel,
  input  logic [DATA_WD-1:0] ms_alu_res,
  input  logic [DATA_WD-1:0] ms_load_raw,
  input  logic [2:0]         ms_load_op,
  input  logic [2:0]         ms_byte_off,
  input  logic [31:0]        ms_pc,
  input  logic               commit_ready,
  output logic               rf_we,
  output logic [ADDR_WD-1:0] rf_waddr,
  output logic [DATA_WD-1:0] rf_wdata,
  output logic               ws_valid,
  output logic [31:0]        ws_pc,
  output logic               ws_retire,
  input  logic [ADDR_WD-1:0] fwd_addr,
  output logic               fwd_hit,
  output logic [DATA_WD-1:0] fwd_data,
  output logic [63:0]        instret
);

  typedef struct packed {
    logic [ADDR_WD-1:0] rd;
    logic               rd_we;
    logic [DATA_WD-1:0] data;
    logic [31:0]        pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t               state, state_nxt;
  entry_t             e0, e1, new_e;
  logic [DATA_WD-1:0] shifted, load_data, res_data;
  logic [31:0]        pc_plus4;
  logic [63:0]        cnt;
  logic               enq, ret;
  logic               e0_new, e0_shift, e1_new;
  logic               hit0, hit1;

  // Result formatting happens before storage so the buffer holds final data.
  always_comb begin
    shifted  = ms_load_raw >> {ms_byte_off, 3'b000};
    pc_plus4 = ms_pc + 32'd4;
    case (ms_load_op)
      3'd0:    load_data = {{(DATA_WD-8){shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{(DATA_WD-16){shifted[15]}}, shifted[15:0]};
      3'd2:    load_data = {{(DATA_WD-32){shifted[31]}}, shifted[31:0]};
      3'd4:    load_data = {{(DATA_WD-8){1'b0}}, shifted[7:0]};
      3'd5:    load_data = {{(DATA_WD-16){1'b0}}, shifted[15:0]};
      3'd6:    load_data = {{(DATA_WD-32){1'b0}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
    case (ms_res_sel)
      2'd1:    res_data = load_data;
      2'd2:    res_data = {{(DATA_WD-32){1'b0}}, pc_plus4};
      default: res_data = ms_alu_res;
    endcase
    new_e = '{rd: ms_rd, rd_we: ms_rd_we, data: res_data, pc: ms_pc};
  end

  assign ws_ready  = !reset && (state != FULL);
  assign ws_valid  = !reset && (state != EMPTY);
  assign ws_retire = ws_valid && commit_ready;
  assign enq       = ms_valid && ws_ready;
  assign ret       = ws_retire;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    e0_new    = 1'b0;
    e0_shift  = 1'b0;
    e1_new    = 1'b0;
    case (state)
      EMPTY: if (enq) begin
        e0_new    = 1'b1;
        state_nxt = ONE;
      end
      ONE: begin
        if (enq && ret) begin
          e0_new = 1'b1;
        end else if (enq) begin
          e1_new    = 1'b1;
          state_nxt = FULL;
        end else if (ret) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (ret) begin
        e0_shift  = 1'b1;
        state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Entry contents need no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (e0_new)        e0 <= new_e;
    else if (e0_shift) e0 <= e1;
    if (e1_new)        e1 <= new_e;
  end

  always_ff @(posedge clk) begin
    if (reset)          cnt <= '0;
    else if (ws_retire) cnt <= cnt + 64'd1;
  end

  assign instret  = reset ? '0 : cnt;
  assign ws_pc    = ws_valid ? e0.pc : '0;
  assign rf_we    = ws_retire && e0.rd_we && (e0.rd != '0);
  assign rf_waddr = e0.rd;
  assign rf_wdata = e0.data;

  // The second slot is the younger entry, so it wins the forwarding lookup.
  assign hit0     = ws_valid && e0.rd_we && (e0.rd != '0) && (e0.rd == fwd_addr);
  assign hit1     = !reset && (state == FULL) && e1.rd_we && (e1.rd != '0) && (e1.rd == fwd_addr);
  assign fwd_hit  = hit0 || hit1;
  assign fwd_data = hit1 ? e1.data : (hit0 ? e0.data : '0);

endmodule

// File: tb/tb_ysyx_22041752_wbu.sv
// Self-checking bench for ysyx_22041752_wbu: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_ysyx_22041752_wbu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ms_valid = 1'b0, ws_ready, ms_rd_we = 1'b0, commit_ready = 1'b0;
  logic [4:0]  ms_rd = '0, rf_waddr, fwd_addr = '0;
  logic [1:0]  ms_res_sel = '0;
  logic [63:0] ms_alu_res = '0, ms_load_raw = '0, rf_wdata, fwd_data, instret;
  logic [2:0]  ms_load_op = '0, ms_byte_off = '0;
  logic [31:0] ms_pc = '0, ws_pc;
  logic        rf_we, ws_valid, ws_retire, fwd_hit;

  int checks = 0;
  int errors = 0;

  ysyx_22041752_wbu #(.DATA_WD(64), .ADDR_WD(5)) dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_ready(ws_ready),
    .ms_rd(ms_rd), .ms_rd_we(ms_rd_we), .ms_res_sel(ms_res_sel),
    .ms_alu_res(ms_alu_res), .ms_load_raw(ms_load_raw), .ms_load_op(ms_load_op),
    .ms_byte_off(ms_byte_off), .ms_pc(ms_pc), .commit_ready(commit_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_valid(ws_valid),
    .ws_pc(ws_pc), .ws_retire(ws_retire), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t            q[$];
  longint unsigned m_cnt = 0;

  function automatic logic [63:0] fmt(input logic [1:0] sel, input logic [2:0] op,
                                      input logic [2:0] off, input logic [63:0] alu,
                                      input logic [63:0] raw, input logic [31:0] pc);
    logic [63:0] s;
    logic [31:0] p4;
    byte         b;
    shortint     h;
    int          w;
    s  = raw >> (8 * int'(off));
    p4 = pc + 32'd4;
    b  = s[7:0];
    h  = s[15:0];
    w  = s[31:0];
    if (sel == 2'd2) return 64'(p4);
    if (sel != 2'd1) return alu;
    case (op)
      3'd0:    return 64'(longint'(b));
      3'd1:    return 64'(longint'(h));
      3'd2:    return 64'(longint'(w));
      3'd4:    return 64'(s[7:0]);
      3'd5:    return 64'(s[15:0]);
      3'd6:    return 64'(s[31:0]);
      default: return s;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state advances on the same edge the DUT samples.
  always @(posedge clk) begin
    bit r, e;
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else begin
      r = (q.size() > 0) && commit_ready;
      e = ms_valid && (q.size() < 2);
      if (r) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (e) q.push_back('{ms_rd, ms_rd_we,
                           fmt(ms_res_sel, ms_load_op, ms_byte_off, ms_alu_res, ms_load_raw, ms_pc),
                           ms_pc});
    end
  end

  always @(negedge clk) begin
    logic        fh, v, r;
    logic [63:0] fd;
    if (reset) begin
      chk("rst_ws_ready", ws_ready, 0);
      chk("rst_ws_valid", ws_valid, 0);
      chk("rst_ws_retire", ws_retire, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_fwd_hit", fwd_hit, 0);
      chk("rst_ws_pc", ws_pc, 0);
      chk("rst_instret", instret, 0);
    end else begin
      v = q.size() > 0;
      r = v && commit_ready;
      chk("ws_ready", ws_ready, q.size() < 2);
      chk("ws_valid", ws_valid, v);
      chk("ws_retire", ws_retire, r);
      chk("ws_pc", ws_pc, v ? q[0].pc : 0);
      chk("rf_we", rf_we, r && q[0].we && q[0].rd != 0);
      if (v) begin
        chk("rf_waddr", rf_waddr, q[0].rd);
        chk("rf_wdata", rf_wdata, q[0].data);
      end
      fh = 0;
      fd = 0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (!fh && q[i].we && q[i].rd != 0 && q[i].rd == fwd_addr) begin
          fh = 1;
          fd = q[i].data;
        end
      chk("fwd_hit", fwd_hit, fh);
      chk("fwd_data", fwd_data, fd);
      chk("instret", instret, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] sel, input logic [2:0] op, input logic [2:0] off,
                        input logic [4:0] rd, input logic we, input logic [63:0] alu,
                        input logic [63:0] raw, input logic [31:0] pc);
    ms_res_sel = sel; ms_load_op = op; ms_byte_off = off; ms_rd = rd;
    ms_rd_we = we; ms_alu_res = alu; ms_load_raw = raw; ms_pc = pc;
  endtask

  task automatic send(input logic [1:0] sel, input logic [2:0] op, input logic [2:0] off,
                      input logic [4:0] rd, input logic we, input logic [63:0] alu,
                      input logic [63:0] raw, input logic [31:0] pc);
    set_in(sel, op, off, rd, we, alu, raw, pc);
    ms_valid = 1'b1;
    cyc();
    ms_valid = 1'b0;
  endtask

  logic [2:0]  s_op[6]  = '{3'd1, 3'd5, 3'd3, 3'd4, 3'd7, 3'd0};
  logic [2:0]  s_off[6] = '{3'd6, 3'd6, 3'd0, 3'd7, 3'd1, 3'd3};
  logic [1:0]  s_sel[6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};

  initial begin
    repeat (2) cyc();
    peek();
    chk("lit_ready_in_reset", ws_ready, 0);
    reset = 1'b0;
    cyc();
    chk("lit_ready_after_release", ws_ready, 1);

    // LB sign extension
    commit_ready = 1'b1;
    send(2'd1, 3'd0, 3'd2, 5'd5, 1'b1, 64'h0, 64'h0000_0000_0080_0000, 32'h1000);
    peek();
    chk("lit_lb_rf_we", rf_we, 1);
    chk("lit_lb_waddr", rf_waddr, 5);
    chk("lit_lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);

    send(2'd1, 3'd6, 3'd4, 5'd6, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 32'h1004);
    peek();
    chk("lit_lwu_wdata", rf_wdata, 64'h0000_0000_DEAD_BEEF);
    send(2'd1, 3'd2, 3'd4, 5'd6, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 32'h1008);
    peek();
    chk("lit_lw_wdata", rf_wdata, 64'hFFFF_FFFF_DEAD_BEEF);
    cyc();

    // Stall with two entries to the same register
    commit_ready = 1'b0;
    send(2'd0, 3'd0, 3'd0, 5'd3, 1'b1, 64'h111, 64'h0, 32'h2000);
    send(2'd0, 3'd0, 3'd0, 5'd3, 1'b1, 64'h222, 64'h0, 32'h2004);
    fwd_addr = 5'd3;
    peek();
    chk("lit_full_ready", ws_ready, 0);
    chk("lit_fwd_youngest_hit", fwd_hit, 1);
    chk("lit_fwd_youngest_data", fwd_data, 64'h222);
    commit_ready = 1'b1;
    #1;
    chk("lit_drain1_wdata", rf_wdata, 64'h111);
    cyc();
    peek();
    chk("lit_drain2_wdata", rf_wdata, 64'h222);
    chk("lit_drain2_rf_we", rf_we, 1);
    cyc();
    peek();
    chk("lit_instret_5", instret, 5);

    // Write to x0 retires without a register write
    fwd_addr = 5'd0;
    send(2'd0, 3'd0, 3'd0, 5'd0, 1'b1, 64'h1234, 64'h0, 32'h3000);
    peek();
    chk("lit_x0_retire", ws_retire, 1);
    chk("lit_x0_rf_we", rf_we, 0);
    chk("lit_x0_fwd_hit", fwd_hit, 0);
    cyc();
    peek();
    chk("lit_instret_6", instret, 6);

    send(2'd2, 3'd0, 3'd0, 5'd7, 1'b1, 64'h0, 64'h0, 32'hFFFF_FFFC);
    peek();
    chk("lit_pc4_wrap", rf_wdata, 0);
    cyc();

    // Back-to-back stream: enqueue and retire together in ONE
    ms_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(s_sel[i], s_op[i], s_off[i], 5'(i + 9), 1'b1, 64'hA5A5_0000 + 64'(i),
             64'h8123_4567_89AB_CDEF, 32'h4000 + 32'(4 * i));
      cyc();
    end
    ms_valid = 1'b0;
    cyc();

    // Mixed traffic with random stalls
    for (int i = 0; i < 80; i++) begin
      ms_valid     = 1'($urandom_range(0, 1));
      commit_ready = ($urandom_range(0, 3) != 0);
      fwd_addr     = 5'($urandom_range(0, 7));
      set_in(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
      cyc();
    end

    // Reset while FULL discards entries
    ms_valid = 1'b0;
    commit_ready = 1'b1;
    repeat (3) cyc();
    commit_ready = 1'b0;
    ms_valid = 1'b1;
    repeat (2) cyc();
    ms_valid = 1'b0;
    chk("lit_prereset_full", ws_ready, 0);
    commit_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("lit_reset_rf_we", rf_we, 0);
    chk("lit_reset_ready", ws_ready, 0);
    chk("lit_reset_instret", instret, 0);
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("lit_release_ready", ws_ready, 1);
    chk("lit_release_valid", ws_valid, 0);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
